multicycle_ctrl: RTL and testbench

//  Control FSM for the multicycle RV32I core variant. One shared ALU/adder and a unified

---
 rtl/multicycle_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I core: sequences FETCH..WRITEBACK over a shared ALU
// and a unified memory port, decodes the latched instruction and drives every datapath select.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUctrl,
    output logic        instr_done,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_MEMWB,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_ctrl;
        logic       instr_done;
        logic       illegal;
        logic       bus_err;
    } ctl_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          state, state_nxt, dec_state;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic            dec_illegal;
    logic [2:0]      alu_op;
    ctl_t            ctl;

    wire [6:0] op     = instr[6:0];
    wire [2:0] func3  = instr[14:12];
    wire       func75 = instr[30];

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Instruction decode: target state after DECODE and legality of op/func3.
    always_comb begin
        dec_state   = S_FETCH;
        dec_illegal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE: dec_state = S_MEMADR;
            OP_R: begin
                dec_state   = S_EXECR;
                dec_illegal = !(func3 inside {3'b000, 3'b010, 3'b110, 3'b111});
            end
            OP_I: begin
                dec_state   = S_EXECI;
                dec_illegal = !(func3 inside {3'b000, 3'b010, 3'b110, 3'b111});
            end
            OP_BR: begin
                dec_state   = S_BRANCH;
                dec_illegal = (func3[2:1] != 2'b00);
            end
            OP_JAL:  dec_state = S_JAL;
            default: dec_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (func3)
            3'b000:  alu_op = (op == OP_R && func75) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_op = ALU_SLT;
            3'b110:  alu_op = ALU_OR;
            3'b111:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ctl       = '0;

        case (state)
            S_FETCH: begin
                ctl.mem_req    = 1'b1;
                ctl.alu_src_b  = 2'b10;
                ctl.result_src = 2'b10;
                if (mem_ready) begin
                    ctl.ir_write = 1'b1;
                    ctl.pc_write = 1'b1;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b01;
                ctl.imm_src   = 2'b10;
                if (dec_illegal) begin
                    ctl.illegal = 1'b1;
                    state_nxt   = S_FETCH;
                end else begin
                    state_nxt = dec_state;
                end
            end
            S_MEMADR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                ctl.imm_src   = (op == OP_STORE) ? 2'b01 : 2'b00;
                state_nxt     = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctl.mem_req = 1'b1;
                ctl.adr_src = 1'b1;
                if (mem_ready) state_nxt = S_MEMWB;
            end
            S_MEMWR: begin
                ctl.mem_req   = 1'b1;
                ctl.mem_write = 1'b1;
                ctl.adr_src   = 1'b1;
                if (mem_ready) begin
                    ctl.instr_done = 1'b1;
                    state_nxt      = S_FETCH;
                end
            end
            S_MEMWB: begin
                ctl.result_src = 2'b01;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_EXECR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b00;
                ctl.alu_ctrl  = alu_op;
                state_nxt     = S_ALUWB;
            end
            S_EXECI: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                ctl.imm_src   = 2'b00;
                ctl.alu_ctrl  = alu_op;
                state_nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.result_src = 2'b00;
                ctl.reg_write  = 1'b1;
                ctl.instr_done = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a  = 2'b10;
                ctl.alu_src_b  = 2'b00;
                ctl.alu_ctrl   = ALU_SUB;
                ctl.instr_done = 1'b1;
                ctl.pc_write   = (func3 == 3'b000 && Zero) || (func3 == 3'b001 && !Zero);
                state_nxt      = S_FETCH;
            end
            S_JAL: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                ctl.imm_src   = 2'b11;
                ctl.pc_write  = 1'b1;
                state_nxt     = S_ALUWB;
            end
            default: state_nxt = S_FETCH;
        endcase

        // Memory watchdog; a completing handshake always beats an expiring count.
        if (!ctl.mem_req || mem_ready) begin
            cnt_nxt = '0;
        end else if (cnt == TO_LIMIT) begin
            cnt_nxt     = '0;
            ctl.bus_err = 1'b1;
            state_nxt   = S_FETCH;
        end else begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    assign {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ImmSrc, ALUctrl, instr_done, illegal, bus_err} = rst_n ? ctl : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle and
// compares the complete control word against hand-derived per-state values.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_ctrl;
        logic       instr_done;
        logic       illegal;
        logic       bus_err;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        Zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]  ALUctrl;
    logic        instr_done, illegal, bus_err;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] cur_instr = '0;
    ctl_t        e;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .instr_done(instr_done),
        .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic ctl_t observed();
        return {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, ALUctrl, instr_done, illegal, bus_err};
    endfunction

    // Expected control words per state, written out from the state descriptions.
    function automatic ctl_t x_fetch(input logic rdy);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
        c.ir_write = rdy; c.pc_write = rdy;
        return c;
    endfunction
    function automatic ctl_t x_decode();
        ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.imm_src = 2'b10;
        return c;
    endfunction
    function automatic ctl_t x_memadr(input logic sw);
        ctl_t c = '0;
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.imm_src = sw ? 2'b01 : 2'b00;
        return c;
    endfunction
    function automatic ctl_t x_memrd();
        ctl_t c = '0;
        c.mem_req = 1'b1; c.adr_src = 1'b1;
        return c;
    endfunction
    function automatic ctl_t x_memwr(input logic rdy);
        ctl_t c = '0;
        c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; c.instr_done = rdy;
        return c;
    endfunction
    function automatic ctl_t x_memwb();
        ctl_t c = '0;
        c.result_src = 2'b01; c.reg_write = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t x_execr(input logic [2:0] aluc);
        ctl_t c = '0;
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b00; c.alu_ctrl = aluc;
        return c;
    endfunction
    function automatic ctl_t x_aluwb();
        ctl_t c = '0;
        c.result_src = 2'b00; c.reg_write = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t x_branch(input logic pcw);
        ctl_t c = '0;
        c.alu_src_a = 2'b10; c.alu_ctrl = 3'b001; c.instr_done = 1'b1; c.pc_write = pcw;
        return c;
    endfunction
    function automatic ctl_t x_jal();
        ctl_t c = '0;
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.imm_src = 2'b11; c.pc_write = 1'b1;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs on the falling edge, let combinational outputs settle.
    task automatic step(input logic rst, input logic rdy, input logic z);
        @(negedge clk);
        rst_n = rst; mem_ready = rdy; Zero = z; instr = cur_instr;
        #1;
    endtask

    task automatic cyc(input string tag, input logic rst, input logic rdy, input logic z,
                       input ctl_t exp);
        step(rst, rdy, z);
        check(tag, 32'(observed()), 32'(exp));
    endtask

    task automatic run_r(input string tag, input logic [31:0] ins, input logic [2:0] aluc);
        cur_instr = ins;
        cyc({tag, ".fetch"}, 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        cyc({tag, ".decode"}, 1'b1, 1'b1, 1'b0, x_decode());
        cyc({tag, ".exec"}, 1'b1, 1'b1, 1'b0, x_execr(aluc));
        cyc({tag, ".wb"}, 1'b1, 1'b1, 1'b0, x_aluwb());
    endtask

    task automatic run_br(input string tag, input logic [31:0] ins, input logic z,
                          input logic pcw);
        cur_instr = ins;
        cyc({tag, ".fetch"}, 1'b1, 1'b1, z, x_fetch(1'b1));
        cyc({tag, ".decode"}, 1'b1, 1'b1, z, x_decode());
        cyc({tag, ".branch"}, 1'b1, 1'b1, z, x_branch(pcw));
    endtask

    initial begin
        // Reset: outputs silent even with mem_ready high.
        cyc("reset0", 1'b0, 1'b1, 1'b0, '0);
        cyc("reset1", 1'b0, 1'b1, 1'b0, '0);

        // R-type ALU ops, zero-wait memory.
        run_r("add", 32'h002081B3, 3'b000);
        run_r("sub", 32'h402081B3, 3'b001);
        run_r("slt", 32'h0020A1B3, 3'b101);
        run_r("or",  32'h0020E1B3, 3'b011);
        run_r("and", 32'h0020F1B3, 3'b010);

        // addi: I-type execute uses the immediate and add.
        cur_instr = 32'h00508093;
        cyc("addi.fetch", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        cyc("addi.decode", 1'b1, 1'b1, 1'b0, x_decode());
        step(1'b1, 1'b1, 1'b0);
        check("addi.exec.aluctrl", 32'(ALUctrl), 32'(3'b000));
        check("addi.exec.srcb", 32'(ALUSrcB), 32'(2'b01));
        check("addi.exec.imm", 32'(ImmSrc), 32'(2'b00));
        check("addi.exec.regwrite", 32'(RegWrite), 32'(1'b0));
        check("addi.exec.memreq", 32'(mem_req), 32'(1'b0));
        cyc("addi.wb", 1'b1, 1'b1, 1'b0, x_aluwb());

        // lw with mem_ready delayed three cycles in MEMRD: 8 cycles total.
        cur_instr = 32'h0000A283;
        cyc("lw.fetch", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        cyc("lw.decode", 1'b1, 1'b1, 1'b0, x_decode());
        cyc("lw.memadr", 1'b1, 1'b1, 1'b0, x_memadr(1'b0));
        for (int i = 0; i < 3; i++) cyc("lw.memrd_wait", 1'b1, 1'b0, 1'b0, x_memrd());
        cyc("lw.memrd_ready", 1'b1, 1'b1, 1'b0, x_memrd());
        cyc("lw.memwb", 1'b1, 1'b1, 1'b0, x_memwb());

        // sw zero-wait.
        cur_instr = 32'h0050A023;
        cyc("sw.fetch", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        cyc("sw.decode", 1'b1, 1'b1, 1'b0, x_decode());
        cyc("sw.memadr", 1'b1, 1'b1, 1'b0, x_memadr(1'b1));
        cyc("sw.memwr", 1'b1, 1'b1, 1'b0, x_memwr(1'b1));

        // Branches: taken/not-taken for both senses.
        run_br("beq_z1", 32'h00208063, 1'b1, 1'b1);
        run_br("beq_z0", 32'h00208063, 1'b0, 1'b0);
        run_br("bne_z1", 32'h00209063, 1'b1, 1'b0);
        run_br("bne_z0", 32'h00209063, 1'b0, 1'b1);

        // Unsupported branch func3: illegal in DECODE, straight back to FETCH.
        cur_instr = 32'h0020C063;
        cyc("blt.fetch", 1'b1, 1'b1, 1'b1, x_fetch(1'b1));
        e = x_decode(); e.illegal = 1'b1;
        cyc("blt.decode_illegal", 1'b1, 1'b1, 1'b1, e);

        // jal: JAL then ALUWB.
        cur_instr = 32'h008000EF;
        cyc("jal.fetch", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        cyc("jal.decode", 1'b1, 1'b1, 1'b0, x_decode());
        cyc("jal.jal", 1'b1, 1'b1, 1'b0, x_jal());
        cyc("jal.wb", 1'b1, 1'b1, 1'b0, x_aluwb());

        // Fetch timeout (limit 4): bus_err on the 5th request cycle, then retry.
        cur_instr = 32'h0050A023;
        for (int i = 0; i < 4; i++) cyc("to.fetch_wait", 1'b1, 1'b0, 1'b0, x_fetch(1'b0));
        e = x_fetch(1'b0); e.bus_err = 1'b1;
        cyc("to.fetch_buserr", 1'b1, 1'b0, 1'b0, e);
        for (int i = 0; i < 4; i++) cyc("to.refetch_wait", 1'b1, 1'b0, 1'b0, x_fetch(1'b0));
        // mem_ready arrives exactly when the count expires: handshake wins.
        cyc("to.ready_wins", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));

        // sw waiting in MEMWR, then reset: request dropped, restart in FETCH.
        cyc("rst.sw_decode", 1'b1, 1'b1, 1'b0, x_decode());
        cyc("rst.sw_memadr", 1'b1, 1'b1, 1'b0, x_memadr(1'b1));
        cyc("rst.memwr_wait0", 1'b1, 1'b0, 1'b0, x_memwr(1'b0));
        cyc("rst.memwr_wait1", 1'b1, 1'b0, 1'b0, x_memwr(1'b0));
        cyc("rst.asserted", 1'b0, 1'b0, 1'b0, '0);
        cyc("rst.released_fetch", 1'b1, 1'b0, 1'b0, x_fetch(1'b0));

        // Unknown opcode: illegal pulse, nothing written, back to FETCH.
        cur_instr = 32'h0000007F;
        cyc("badop.fetch", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        e = x_decode(); e.illegal = 1'b1;
        cyc("badop.decode_illegal", 1'b1, 1'b1, 1'b0, e);
        cur_instr = 32'h00109093;
        cyc("badop.next_fetch", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        // I-type with unsupported func3 (slli).
        cyc("slli.decode_illegal", 1'b1, 1'b1, 1'b0, e);

        // lw whose data never arrives: timeout abandons MEMRD without retiring.
        cur_instr = 32'h0000A283;
        cyc("lwto.fetch", 1'b1, 1'b1, 1'b0, x_fetch(1'b1));
        cyc("lwto.decode", 1'b1, 1'b1, 1'b0, x_decode());
        cyc("lwto.memadr", 1'b1, 1'b1, 1'b0, x_memadr(1'b0));
        for (int i = 0; i < 4; i++) cyc("lwto.memrd_wait", 1'b1, 1'b0, 1'b0, x_memrd());
        e = x_memrd(); e.bus_err = 1'b1;
        cyc("lwto.buserr", 1'b1, 1'b0, 1'b0, e);
        cyc("lwto.refetch", 1'b1, 1'b0, 1'b0, x_fetch(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
